// File: rtl/rgb2raw.sv
// rgb2raw: Bayer re-mosaic of a timed 24-bit RGB stream into a RAW8 stream.
// Every output lags its inputs by exactly one sclk, and sync/DE timing is
// preserved. BAYER_PAT selects the CFA phase of pixel (row 0, col 0):
// 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
// Optional macro RGB2RAW_STATS_EN compiles in the frame counter, line-width
// tracking, the stats FSM and the sticky width-error flag. Without it those
// outputs are tied to zero and no stats registers exist.
module rgb2raw #(
  parameter logic [1:0] BAYER_PAT = 2'd0
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        i_vga_vsync,
  input  logic        i_vga_hsync,
  input  logic        i_vga_de,
  input  logic [7:0]  i_vga_r,
  input  logic [7:0]  i_vga_g,
  input  logic [7:0]  i_vga_b,
  output logic        o_vga_vsync,
  output logic        o_vga_hsync,
  output logic        o_vga_de,
  output logic [7:0]  raw_data,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_line_width,
  output logic        o_width_err
);

  logic        vsync_q, vsync_d;
  logic        hsync_q, hsync_d;
  logic        de_q, de_d;
  logic [7:0]  raw_q, raw_d;
  logic [15:0] col_cnt_q, col_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;
  logic [1:0]  phase;
  logic        de_fall;

  // Pixel position tracking and CFA sample selection, all from pre-update counters
  always_comb begin
    vsync_d   = i_vga_vsync;
    hsync_d   = i_vga_hsync;
    de_d      = i_vga_de;
    de_fall   = ~i_vga_de & de_q;
    col_cnt_d = i_vga_de ? col_cnt_q + 16'd1 : 16'd0;
    row_cnt_d = row_cnt_q;
    if (i_vga_vsync) begin
      row_cnt_d = 16'd0;
    end else if (de_fall) begin
      row_cnt_d = row_cnt_q + 16'd1;
    end
    phase = {row_cnt_q[0], col_cnt_q[0]} ^ BAYER_PAT;
    raw_d = 8'h00;
    if (i_vga_de) begin
      case (phase)
        2'b00:   raw_d = i_vga_r;
        2'b11:   raw_d = i_vga_b;
        default: raw_d = i_vga_g;
      endcase
    end
  end

  // Datapath registers: one-cycle delayed sync/DE, RAW sample and counters
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vsync_q   <= 1'b0;
      hsync_q   <= 1'b0;
      de_q      <= 1'b0;
      raw_q     <= 8'h00;
      col_cnt_q <= 16'd0;
      row_cnt_q <= 16'd0;
    end else begin
      vsync_q   <= vsync_d;
      hsync_q   <= hsync_d;
      de_q      <= de_d;
      raw_q     <= raw_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign o_vga_vsync = vsync_q;
  assign o_vga_hsync = hsync_q;
  assign o_vga_de    = de_q;
  assign raw_data    = raw_q;

`ifdef RGB2RAW_STATS_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_CHECK
  } stats_state_e;

  stats_state_e state_q, state_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0]  line_width_q, line_width_d;
  logic [15:0]  ref_width_q, ref_width_d;
  logic         width_err_q, width_err_d;
  logic         vsync_rise;

  // Stats next state: a vsync rise opens a new frame and takes priority over a
  // same-cycle line end, so a line cut by vsync is never checked against it
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    line_width_d = line_width_q;
    ref_width_d  = ref_width_q;
    width_err_d  = width_err_q;
    vsync_rise   = i_vga_vsync & ~vsync_q;
    if (vsync_rise) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      width_err_d = 1'b0;
      state_d     = ST_FIRST;
    end else if (de_fall) begin
      line_width_d = col_cnt_q;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FIRST: begin
          ref_width_d = col_cnt_q;
          state_d     = ST_CHECK;
        end
        ST_CHECK: begin
          if (col_cnt_q != ref_width_q) begin
            width_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Stats registers
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= 16'd0;
      line_width_q <= 16'd0;
      ref_width_q  <= 16'd0;
      width_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      line_width_q <= line_width_d;
      ref_width_q  <= ref_width_d;
      width_err_q  <= width_err_d;
    end
  end

  assign o_frame_cnt  = frame_cnt_q;
  assign o_line_width = line_width_q;
  assign o_width_err  = width_err_q;
`else
  assign o_frame_cnt  = 16'd0;
  assign o_line_width = 16'd0;
  assign o_width_err  = 1'b0;
`endif

endmodule
